// File: rtl/tone_direction_decoder.sv
// Tone frequency to junction-direction decoder: times rising edges of the squared tone, confirms a band over
// several periods and locks a TD_* code while enabled. Optional input glitch filter: TONE_GLITCH_FILTER_EN.
module tone_direction_decoder #(
    parameter int PER_STRAIGHT  = 50000,
    parameter int PER_LEFT      = 25000,
    parameter int PER_RIGHT     = 16667,
    parameter int PER_BACK      = 12500,
    parameter int PER_STOP      = 10000,
    parameter int PER_TOL       = 500,
    parameter int CONFIRM_COUNT = 16,
    parameter int MAX_PERIOD    = 65535,
    parameter int GLITCH_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enableToneDetection,
    input  logic        toneIn,
    output logic [2:0]  toneDir,
    output logic        toneLocked,
    output logic [16:0] lastPeriod
);

    localparam logic [2:0] TD_HOLD     = 3'd0;
    localparam logic [2:0] TD_STRAIGHT = 3'd1;
    localparam logic [2:0] TD_LEFT     = 3'd2;
    localparam logic [2:0] TD_RIGHT    = 3'd3;
    localparam logic [2:0] TD_BACK     = 3'd4;
    localparam logic [2:0] TD_STOP     = 3'd5;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_LOCKED  = 2'd3;

    logic [1:0]  syncFf;
    logic        toneLevel;
    logic        prevLevel;
    logic        edgePulse;
    logic [1:0]  state;
    logic [16:0] periodCnt;
    logic [4:0]  matchCount;
    logic [2:0]  matchBand;
    logic [2:0]  periodBand;
    logic [4:0]  countNext;
    logic        saturated;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) syncFf <= 2'b00;
        else     syncFf <= {syncFf[0], toneIn};
    end

`ifdef TONE_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    logic          filtLevel;
    logic [GW-1:0] glitchCnt;

    // Level follows the synchronizer only after it has disagreed for more than GLITCH_CYCLES samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filtLevel <= 1'b0;
            glitchCnt <= '0;
        end else if (syncFf[1] == filtLevel) begin
            glitchCnt <= '0;
        end else if (glitchCnt == GW'(GLITCH_CYCLES)) begin
            filtLevel <= syncFf[1];
            glitchCnt <= '0;
        end else begin
            glitchCnt <= glitchCnt + 1'b1;
        end
    end

    assign toneLevel = filtLevel;
`else
    assign toneLevel = syncFf[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevLevel <= 1'b0;
            edgePulse <= 1'b0;
        end else begin
            prevLevel <= toneLevel;
            edgePulse <= toneLevel & ~prevLevel;
        end
    end

    function automatic logic inBand(input logic [16:0] p, input int centre);
        int pi;
        pi = int'({15'd0, p});
        return (pi >= centre - PER_TOL) && (pi <= centre + PER_TOL);
    endfunction

    function automatic logic [2:0] classify(input logic [16:0] p);
        logic [2:0] band;
        band = TD_HOLD;
        if      (inBand(p, PER_STRAIGHT)) band = TD_STRAIGHT;
        else if (inBand(p, PER_LEFT))     band = TD_LEFT;
        else if (inBand(p, PER_RIGHT))    band = TD_RIGHT;
        else if (inBand(p, PER_BACK))     band = TD_BACK;
        else if (inBand(p, PER_STOP))     band = TD_STOP;
        return band;
    endfunction

    assign periodBand = classify(periodCnt);
    assign saturated  = (periodCnt == 17'(MAX_PERIOD));

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        countNext = 5'd0;
        if (periodBand != TD_HOLD)
            countNext = (periodBand == matchBand) ? matchCount + 5'd1 : 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            toneDir    <= TD_HOLD;
            toneLocked <= 1'b0;
            lastPeriod <= '0;
            periodCnt  <= '0;
            matchCount <= '0;
            matchBand  <= TD_HOLD;
        end else if (!enableToneDetection) begin
            state      <= S_IDLE;
            toneDir    <= TD_HOLD;
            toneLocked <= 1'b0;
            periodCnt  <= '0;
            matchCount <= '0;
            matchBand  <= TD_HOLD;
        end else begin
            case (state)
                S_IDLE: begin
                    state     <= S_ARM;
                    periodCnt <= '0;
                end
                S_ARM: begin
                    // The first edge only starts timing; its stale count is never classified.
                    if (edgePulse) begin
                        periodCnt <= 17'd1;
                        state     <= S_MEASURE;
                    end else if (!saturated) begin
                        periodCnt <= periodCnt + 17'd1;
                    end
                end
                S_MEASURE: begin
                    if (edgePulse) begin
                        lastPeriod <= periodCnt;
                        periodCnt  <= 17'd1;
                        matchCount <= countNext;
                        if (periodBand != TD_HOLD) matchBand <= periodBand;
                        if (countNext == 5'(CONFIRM_COUNT)) begin
                            toneDir    <= periodBand;
                            toneLocked <= 1'b1;
                            state      <= S_LOCKED;
                        end
                    end else if (saturated) begin
                        matchCount <= '0;
                        state      <= S_ARM;
                    end else begin
                        periodCnt <= periodCnt + 17'd1;
                    end
                end
                default: ; // S_LOCKED: hold the code until the enable drops
            endcase
        end
    end

endmodule
